// File: rtl/rx_frame_fifo_if.sv
// rx_frame_fifo_if: frame input, read handshake and status bundle for rx_frame_fifo
interface rx_frame_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH+1:0] frame_in;
  logic                  frame_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  framing_error;
  logic                  overflow;
  logic                  clear_errors;
  modport master (
    output frame_in, frame_valid, rd_ready, clear_errors,
    input  rd_data, rd_valid, count, framing_error, overflow
  );
  modport slave (
    input  frame_in, frame_valid, rd_ready, clear_errors,
    output rd_data, rd_valid, count, framing_error, overflow
  );
endinterface

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: checks UART frames and queues good bytes with sticky error flags
module rx_frame_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic           clk,
  input logic           reset,
  rx_frame_fifo_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  fe, ov, good, full, pop, push;
  // Frame check and handshake decode; full/empty come from the count alone
  always_comb begin
    good = !bus.frame_in[0] && bus.frame_in[DATA_WIDTH+1];
    full = cnt == (ADDR_WIDTH+1)'(DEPTH);
    pop  = bus.rd_valid && bus.rd_ready;
    push = bus.frame_valid && good && (!full || pop);
  end
  // Storage is not reset; entries become invisible once the count is cleared
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.frame_in[DATA_WIDTH:1];
  // Pointers, occupancy and sticky flags; a set condition beats clear_errors
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      fe     <= 1'b0;
      ov     <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(pop);
      cnt    <= cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      fe     <= (bus.frame_valid && !good) || (fe && !bus.clear_errors);
      ov     <= (bus.frame_valid && good && full && !pop) || (ov && !bus.clear_errors);
    end
  end
  assign bus.rd_valid      = cnt != '0;
  assign bus.rd_data       = bus.rd_valid ? mem[rd_ptr] : '0;
  assign bus.count         = cnt;
  assign bus.framing_error = fe;
  assign bus.overflow      = ov;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: table vectors, directed corners and random traffic against a queue model
module tb_rx_frame_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;
  rx_frame_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  logic [7:0] mq[$];
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  logic       popped;
  logic [7:0] popped_data;

  typedef struct {
    logic       rst;
    logic       fv;
    logic [9:0] fin;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_fe;
    logic       e_ov;
  } vec_t;
  vec_t vt[$];

  function automatic logic [9:0] gf(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic fv, input logic [9:0] fin,
                      input logic rdy, input logic clr);
    logic good, p, w;
    reset = rst;
    bus.frame_valid = fv;
    bus.frame_in = fin;
    bus.rd_ready = rdy;
    bus.clear_errors = clr;
    #1;
    popped = !rst && bus.rd_valid && rdy;
    popped_data = bus.rd_data;
    if (rst) begin
      mq.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      good = !fin[0] && fin[9];
      p = (mq.size() > 0) && rdy;
      w = fv && good && (mq.size() < 8 || p);
      m_fe = (fv && !good) || (m_fe && !clr);
      m_ov = (fv && good && mq.size() == 8 && !p) || (m_ov && !clr);
      if (p) void'(mq.pop_front());
      if (w) mq.push_back(fin[8:1]);
    end
    @(posedge clk);
    #1;
    chk("model_valid", int'(bus.rd_valid), int'(mq.size() > 0));
    chk("model_data", int'(bus.rd_data), mq.size() > 0 ? int'(mq[0]) : 0);
    chk("model_count", int'(bus.count), mq.size());
    chk("model_fe", int'(bus.framing_error), int'(m_fe));
    chk("model_ov", int'(bus.overflow), int'(m_ov));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 10'h200, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] ins[$];
    logic [7:0] outs[$];
    int cyc;
    bus.frame_valid = 1'b0;
    bus.frame_in = '0;
    bus.rd_ready = 1'b0;
    bus.clear_errors = 1'b0;

    vt.push_back('{1, 0, 10'h000, 0, 0, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 1, 10'b1_01010101_0, 0, 0, 1, 8'h55, 1, 0, 0});
    for (int i = 0; i < 5; i++) vt.push_back('{0, 0, 10'h000, 0, 0, 1, 8'h55, 1, 0, 0});
    vt.push_back('{0, 0, 10'h000, 1, 0, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 10'h000, 1, 0, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 1, 10'b0_11110000_0, 0, 0, 0, 8'h00, 0, 1, 0});
    vt.push_back('{0, 1, 10'b1_00001111_1, 0, 0, 0, 8'h00, 0, 1, 0});
    vt.push_back('{0, 0, 10'h000, 0, 1, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 1, 10'b1_00001111_1, 0, 1, 0, 8'h00, 0, 1, 0});
    vt.push_back('{0, 1, 10'b1_11001100_0, 0, 1, 1, 8'hCC, 1, 0, 0});
    vt.push_back('{0, 0, 10'h000, 1, 0, 0, 8'h00, 0, 0, 0});
    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].fv, vt[i].fin, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(bus.rd_valid), int'(vt[i].e_valid));
      chk($sformatf("vec%0d_data", i), int'(bus.rd_data), int'(vt[i].e_data));
      chk($sformatf("vec%0d_count", i), int'(bus.count), vt[i].e_count);
      chk($sformatf("vec%0d_fe", i), int'(bus.framing_error), int'(vt[i].e_fe));
      chk($sformatf("vec%0d_ov", i), int'(bus.overflow), int'(vt[i].e_ov));
    end

    step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, gf(8'(i)), 1'b0, 1'b0);
    step(1'b0, 1'b1, gf(8'hAA), 1'b0, 1'b0);
    chk("ovf_count", int'(bus.count), 8);
    chk("ovf_flag", int'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", int'(bus.rd_data), i);
      idle(1'b1);
    end
    chk("ovf_empty", int'(bus.rd_valid), 0);
    chk("ovf_no_aa", int'(bus.rd_data), 0);

    step(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, gf(8'h10 + 8'(i)), 1'b0, 1'b0);
    step(1'b0, 1'b1, gf(8'h3C), 1'b1, 1'b0);
    chk("pp_count", int'(bus.count), 8);
    chk("pp_ovf", int'(bus.overflow), 0);
    chk("pp_head", int'(bus.rd_data), 8'h11);
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain", int'(bus.rd_data), i == 7 ? 8'h3C : 8'h11 + i);
      idle(1'b1);
    end

    for (int i = 0; i < 20; i++) ins.push_back(8'($urandom));
    begin
      int n = 0;
      cyc = 0;
      while ((n < 20 || outs.size() < 20) && cyc < 2000) begin
        logic r, f;
        r = 1'($urandom);
        f = (n < 20) && 1'($urandom) && (mq.size() < 8 || r);
        step(1'b0, f, f ? gf(ins[n]) : 10'h0, r, 1'b0);
        if (popped) outs.push_back(popped_data);
        if (f) n++;
        chk("rnd_max", int'(bus.count <= 8), 1);
        cyc++;
      end
    end
    chk("rnd_done", outs.size(), 20);
    foreach (outs[i]) chk("rnd_order", int'(outs[i]), i < ins.size() ? int'(ins[i]) : -1);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, gf(8'h40 + 8'(i)), 1'b0, 1'b0);
    step(1'b0, 1'b1, gf(8'hEE), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("rst_pre_count", int'(bus.count), 5);
    chk("rst_pre_ov", int'(bus.overflow), 1);
    step(1'b1, 1'b1, gf(8'h99), 1'b0, 1'b1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_ov", int'(bus.overflow), 0);
    chk("rst_fe", int'(bus.framing_error), 0);
    idle(1'b0);
    chk("rst_no_write", int'(bus.count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
